// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands an LM/SM register mask into one register/memory transfer per cycle,
// lowest register first, stepping the word address on every accepted transfer.
module lm_sm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [15:0] base_addr,
    input  logic [7:0]  reg_list,
    input  logic        mem_stall,
    output logic        busy,
    output logic        op_valid,
    output logic        op_store,
    output logic [2:0]  op_reg,
    output logic [15:0] op_addr,
    output logic        done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] addr_q, addr_d;
    logic        store_q, store_d;
    logic        done_q, done_d;
    logic [2:0]  low;
    always_comb begin
        low = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (mask_q[i]) low = 3'(i);
    end
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        store_d = store_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start && reg_list != 8'd0) begin
                mask_d  = reg_list;
                addr_d  = base_addr;
                store_d = is_store;
                state_d = RUN;
            end else begin
                done_d = start;
            end
        end else if (!mem_stall) begin
            // clearing the lowest set bit retires the transfer being presented
            mask_d = mask_q & (mask_q - 8'd1);
            addr_d = addr_q + 16'd1;
            if (mask_d == 8'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            addr_q  <= 16'd0;
            store_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            done_q  <= done_d;
        end
    end
    assign busy     = state_q == RUN;
    assign op_valid = busy;
    assign op_store = busy & store_q;
    assign op_reg   = busy ? low : 3'd0;
    assign op_addr  = busy ? addr_q : 16'd0;
    assign done     = done_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: directed and randomized LM/SM sequences checked against a
// transfer-queue model built from the register mask.
module tb_lm_sm_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [15:0] base_addr = 16'd0;
    logic [7:0]  reg_list = 8'd0;
    logic        mem_stall = 1'b0;
    logic        busy, op_valid, op_store, done;
    logic [2:0]  op_reg;
    logic [15:0] op_addr;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [22:0] obs;

    lm_sm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_list(reg_list), .mem_stall(mem_stall),
        .busy(busy), .op_valid(op_valid), .op_store(op_store),
        .op_reg(op_reg), .op_addr(op_addr), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {busy, op_valid, op_store, op_reg, op_addr, done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [15:0] base, input logic [7:0] list);
        start = 1'b1;
        is_store = st;
        base_addr = base;
        reg_list = list;
    endtask

    // Steps from the issue cycle to the done cycle, checking every transfer against
    // a queue of register indices derived from the mask; returns at the done cycle.
    task automatic follow(input string name, input logic st, input logic [15:0] base,
                          input logic [7:0] list, input logic [15:0] stall_at,
                          input bit rnd, input int poke, output int cycles);
        int regs[$];
        int n;
        logic [15:0] a;
        logic [22:0] exp;
        logic stall;
        for (int i = 0; i < 8; i++)
            if (list[i]) regs.push_back(i);
        a = base;
        n = 0;
        step();
        cycles = 1;
        start = 1'b0;
        while (regs.size() > 0) begin
            exp = {1'b1, 1'b1, st, 3'(regs[0]), a, 1'b0};
            total_cnt++;
            if (obs !== exp)
                $display("FAIL %s xfer%0d: got %h expected %h", name, n, obs, exp);
            else
                pass_cnt++;
            stall = rnd ? ($urandom_range(3) == 0) : (n < 16 && stall_at[n]);
            mem_stall = stall;
            if (n == poke) begin
                start = 1'b1;
                is_store = ~st;
                base_addr = 16'($urandom);
                reg_list = 8'($urandom) | 8'h01;
            end
            step();
            cycles++;
            n++;
            start = 1'b0;
            if (!stall) begin
                void'(regs.pop_front());
                a = a + 16'd1;
            end
            if (cycles > 200) break;
        end
        mem_stall = 1'b0;
        exp = 23'd1;
        total_cnt++;
        if (obs !== exp)
            $display("FAIL %s done: got %h expected %h", name, obs, exp);
        else
            pass_cnt++;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            step();
            total_cnt++;
            if (obs !== 23'd0)
                $display("FAIL idle: got %h expected %h", obs, 23'd0);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (obs !== 23'd0) $display("FAIL reset: got %h expected 0", obs);
        else pass_cnt++;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_lm();
        int c;
        issue(1'b0, 16'h0010, 8'b1000_0101);
        follow("lm", 1'b0, 16'h0010, 8'b1000_0101, 16'd0, 1'b0, -1, c);
        total_cnt++;
        if (c !== 4) $display("FAIL lm_latency: got %0d expected 4", c);
        else pass_cnt++;
        idle(1);
    endtask

    task automatic test_sm_stall();
        int c;
        issue(1'b1, 16'h0100, 8'hFF);
        follow("sm_stall", 1'b1, 16'h0100, 8'hFF, 16'b1100, 1'b0, -1, c);
        total_cnt++;
        if (c !== 11) $display("FAIL sm_latency: got %0d expected 11", c);
        else pass_cnt++;
        idle(1);
    endtask

    task automatic test_wrap();
        int c;
        issue(1'b0, 16'hFFFF, 8'b0000_0011);
        follow("wrap", 1'b0, 16'hFFFF, 8'b0000_0011, 16'd0, 1'b0, -1, c);
        idle(1);
    endtask

    task automatic test_empty();
        int c;
        issue(1'b1, 16'h1234, 8'h00);
        total_cnt++;
        if (obs !== 23'd0) $display("FAIL empty_issue: got %h expected 0", obs);
        else pass_cnt++;
        follow("empty", 1'b1, 16'h1234, 8'h00, 16'd0, 1'b0, -1, c);
        total_cnt++;
        if (c !== 1) $display("FAIL empty_latency: got %0d expected 1", c);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_back_to_back();
        int c;
        issue(1'b0, 16'h0040, 8'b0101_0010);
        follow("busy_start", 1'b0, 16'h0040, 8'b0101_0010, 16'd0, 1'b0, 1, c);
        issue(1'b1, 16'h0800, 8'b0000_1001);
        follow("b2b", 1'b1, 16'h0800, 8'b0000_1001, 16'b10, 1'b0, -1, c);
        total_cnt++;
        if (c !== 4) $display("FAIL b2b_latency: got %0d expected 4", c);
        else pass_cnt++;
        idle(1);
    endtask

    task automatic test_reset_mid_run();
        int c;
        logic [22:0] exp;
        issue(1'b0, 16'h2000, 8'b0011_1110);
        step();
        start = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 3'd1, 16'h2000, 1'b0};
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_run0: got %h expected %h", obs, exp);
        else pass_cnt++;
        step();
        step();
        exp = {1'b1, 1'b1, 1'b0, 3'd3, 16'h2002, 1'b0};
        total_cnt++;
        if (obs !== exp) $display("FAIL rst_run2: got %h expected %h", obs, exp);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (obs !== 23'd0) $display("FAIL rst_async: got %h expected 0", obs);
        else pass_cnt++;
        idle(2);
        rst = 1'b0;
        issue(1'b1, 16'h3000, 8'h81);
        follow("after_rst", 1'b1, 16'h3000, 8'h81, 16'd0, 1'b0, -1, c);
        idle(1);
    endtask

    task automatic test_random();
        int c;
        logic st;
        logic [15:0] b;
        logic [7:0] l;
        int p;
        for (int k = 0; k < 30; k++) begin
            st = 1'($urandom);
            b = (k % 5 == 0) ? 16'hFFFE : 16'($urandom);
            l = (k % 7 == 3) ? 8'h00 : 8'($urandom);
            p = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : -1;
            issue(st, b, l);
            follow("random", st, b, l, 16'd0, 1'b1, p, c);
            if ($urandom_range(1) == 1) idle(int'($urandom_range(2, 1)));
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_lm();
        test_sm_stall();
        test_wrap();
        test_empty();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, decode presents a valid LM/SM instruction this cycle.
REQ-004 SHALL have port is_store, input, 1, 0 = LM (load multiple), 1 = SM (store multiple), sampled with start.
REQ-005 SHALL have port base_addr, input, 16, contents of RA (starting memory word address), sampled with start.
REQ-006 SHALL have port reg_list, input, 8, immediate register mask (bit i selects Ri), sampled with start.
REQ-007 SHALL have port mem_stall, input, 1, memory stage cannot accept a transfer this cycle.
REQ-008 SHALL have port busy, output, 1, sequencer in RUN, and upstream fetch/decode SHALL hold.
REQ-009 SHALL have port op_valid, output, 1, a register/memory transfer is presented this cycle.
REQ-010 SHALL have port op_store, output, 1, latched is_store for the presented transfer.
REQ-011 SHALL have port op_reg, output, 3, register index of the presented transfer.
REQ-012 SHALL have port op_addr, output, 16, memory word address of the presented transfer.
REQ-013 SHALL have port done, output, 1, one-cycle pulse, instruction fully sequenced.

Function
REQ-014 SHALL implement two states, IDLE and RUN, and busy = (state == RUN).
REQ-015 In IDLE with start=1 and reg_list!=0, SHALL latch reg_list into mask_q, base_addr into addr_q and is_store into store_q, then enter RUN next cycle.
REQ-016 In IDLE with start=1 and reg_list==0, SHALL stay IDLE, issue no transfer, and assert done for exactly one cycle on the next cycle.
REQ-017 In RUN, op_valid SHALL be 1, op_reg SHALL be the index of the lowest set bit of mask_q, op_addr = addr_q, and op_store = store_q.
REQ-018 A transfer SHALL be accepted in a RUN cycle with mem_stall=0: clear that bit of mask_q and set addr_q = addr_q + 1 (16-bit, 16'hFFFF wraps to 16'h0000).
REQ-019 With mem_stall=1, mask_q, addr_q, op_reg, op_addr and op_store SHALL hold unchanged, and op_valid SHALL stay 1.
REQ-020 When the accepted transfer clears the last set bit, SHALL return to IDLE next cycle and assert done for exactly one cycle on that next cycle.
REQ-021 Latency: start at cycle N and no stalls give transfers at N+1..N+k for k set bits, and done at N+k+1.
REQ-022 start asserted while busy=1 SHALL be ignored, with no relatch.
REQ-023 start on the same cycle done is high (state IDLE) SHALL be accepted normally, giving back-to-back instructions.
REQ-024 Outside RUN, op_valid SHALL be 0, and op_reg, op_addr and op_store SHALL be 0.
REQ-025 done SHALL be registered; all other outputs SHALL be derived from state and registers only, with no combinational path from inputs.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, mask_q=0, addr_q=0, store_q=0 and done=0, so that busy=0, op_valid=0, op_reg=0, op_addr=0 and op_store=0.
REQ-027 rst asserted mid-RUN SHALL abandon the instruction: no further transfers and no done pulse.
REQ-028 After rst deasserts, SHALL accept start on the first clock edge.

Verification
REQ-029 Bench SHALL cover LM: start, is_store=0, base_addr=16'h0010, reg_list=8'b1000_0101 -> op_reg 0,2,7 at addr 0010,0011,0012 on consecutive cycles, done one cycle after the third.
REQ-030 Bench SHALL cover SM with stall: reg_list=8'hFF, base_addr=16'h0100, mem_stall=1 on the 3rd transfer cycle for 2 cycles -> R2/0102 held 3 cycles, done at cycle 11 after start.
REQ-031 Bench SHALL cover address wrap: base_addr=16'hFFFF, reg_list=8'b0000_0011 -> R0@FFFF, R1@0000.
REQ-032 Bench SHALL cover an empty list: reg_list=8'h00 -> op_valid never 1, busy never 1, done pulses at N+1.
REQ-033 Bench SHALL cover start while busy, plus start on the done cycle -> first ignored, mask unchanged; second instruction begins the next cycle.
REQ-034 Bench SHALL cover reset mid-RUN: rst after 2 of 5 transfers -> all outputs 0 asynchronously, no done pulse, new start accepted after release.
